tiny_dnn_seq: RTL
=================

Name: tiny_dnn_seq

Overview:
- Sequencer driving the control side of the tiny_dnn_core MAC/weight-memory interface: the initiator for that responder.
- Load command: streams N weights plus one bias into the core.
- Run command: issues init, N exec beats, one bias beat; waits out the core's 2-stage pipeline, then presents a result-valid handshake for capturing sum.
- Data (d, wd, sum) bypasses this block; it generates strobes, address and handshakes only.

Parameters:
- f_size, 1024, core weight depth; address f_size-1 is the bias slot.
- aw, 10, address width = clog2(f_size).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_load  in  1  begin weight load; sampled in IDLE only
- start_run  in  1  begin one dot product; sampled in IDLE only
- n_terms  in  aw  term count N, latched on accepted start
- wd_valid  in  1  weight word present on external wd bus
- wd_ready  out  1  sequencer accepts current wd word
- init  out  1  to core: clear sum
- write  out  1  to core: write wd
- bwrite  out  1  to core: force address f_size-1
- exec  out  1  to core: MAC beat
- bias  out  1  to core: add bias beat
- a  out  aw  to core weight address; also input-buffer read address for d
- busy  out  1  high in any state except IDLE
- load_done  out  1  one-cycle pulse after bias word written
- res_valid  out  1  core sum is final
- res_ready  in  1  consumer has taken sum

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0. All outputs 0: init, write, bwrite, exec, bias, a, wd_ready, busy, load_done, res_valid. Core sum is not cleared; every run starts with init.
- Latched N = min(n_terms, f_size-1).
- start_load and start_run together in IDLE: load wins, run dropped. Starts while busy are ignored.
- States: IDLE, LW, LB, INIT, RUN, BIAS, DR1, DR2, RES.
- IDLE -> LW on start_load (N>0); -> LB if N=0.
- LW: wd_ready=1, a=cnt.
  - write = wd_valid, same cycle (combinational).
  - On a write, cnt++. After the write with cnt=N-1 -> LB.
  - wd_valid low stalls with no write.
- LB: wd_ready=1, a=f_size-1.
  - On wd_valid: write=1, bwrite=1, load_done=1 same cycle -> IDLE.
- IDLE -> INIT on start_run. INIT: init=1 for one cycle. Then -> RUN (N>0) or -> BIAS (N=0).
- RUN: exec=1, a=cnt, cnt 0..N-1, one beat per cycle, no stalls. After the beat with cnt=N-1 -> BIAS.
  - The d source must present d[a] in the cycle after exec for a (synchronous-read buffer).
- BIAS: bias=1, a=f_size-1, one cycle -> DR1 -> DR2 -> RES.
- RES: res_valid=1 until res_ready=1, then -> IDLE.
  - Core sum is stable throughout RES.
  - res_ready outside RES is ignored.
- Latency for N terms: start_run accepted at edge 0; init in cycle 1; exec cycles 2..N+1; bias cycle N+2; res_valid first high in cycle N+5.
- Strobe rules:
  - init is never high with exec or bias.
  - exec and bias are never both high.
  - write is only high in LW or LB.
- Mid-operation reset: outputs drop immediately. A partial load leaves the core memory partially updated; this is legal.

Test Plan:
- Reset: hold rst_n=0 during RUN -> all outputs 0 asynchronously; after release, busy=0 and state IDLE.
- Load N=3: 4 wd words, wd_valid gapped 1-0-1-1-1 -> write at a=0,1,2; final word gives write=bwrite=1 with a=1023; load_done pulses once; 4 writes total.
- Run N=4 with weights 1,2,3,4, bias 0.5, d=1,1,1,1 -> exec cycles 2..5 a=0..3; bias in cycle 6; res_valid in cycle 9; core sum=10.5.
- Run N=0 -> init, then bias, then res_valid in cycle 5; sum equals bias.
- Backpressure: res_ready low 5 cycles -> res_valid holds; start_run pulses meanwhile are ignored. res_ready=1 -> IDLE next cycle.
- Collisions and clamp:
  - start_load and start_run together -> load sequence only.
  - n_terms=1023 on run -> clamped: exec a=0..1022, never 1023 on an exec beat.

Source files
------------

// File: rtl/tiny_dnn_seq.sv
// Control sequencer for the tiny_dnn_core MAC / weight-memory responder.
// Generates strobes, weight address and handshakes for weight loads and dot-product runs.
module tiny_dnn_seq #(
  parameter int f_size = 1024,
  parameter int aw     = $clog2(f_size)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_load,
  input  logic          start_run,
  input  logic [aw-1:0] n_terms,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic          init,
  output logic          write,
  output logic          bwrite,
  output logic          exec,
  output logic          bias,
  output logic [aw-1:0] a,
  output logic          busy,
  output logic          load_done,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int unsigned   bias_addr_i = f_size - 1;
  localparam logic [aw-1:0] bias_addr   = bias_addr_i[aw-1:0];

  typedef enum logic [3:0] {
    st_idle, st_lw, st_lb, st_init, st_run, st_bias, st_dr1, st_dr2, st_res
  } state_t;

  state_t        state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic [aw-1:0] n_q, n_d;
  logic [aw-1:0] n_clamp;
  logic          cnt_last;

  // The bias slot is never a term address, so N saturates one below f_size.
  assign n_clamp  = (int'(n_terms) > f_size - 1) ? bias_addr : n_terms;
  assign cnt_last = (cnt_q == n_q - aw'(1));
  assign busy     = (state_q != st_idle);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the case can leave a signal unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    wd_ready  = 1'b0;
    init      = 1'b0;
    write     = 1'b0;
    bwrite    = 1'b0;
    exec      = 1'b0;
    bias      = 1'b0;
    a         = '0;
    load_done = 1'b0;
    res_valid = 1'b0;

    unique case (state_q)
      st_idle: begin
        // Load has priority when both commands arrive in the same cycle.
        if (start_load) begin
          n_d     = n_clamp;
          cnt_d   = '0;
          state_d = (n_clamp != '0) ? st_lw : st_lb;
        end else if (start_run) begin
          n_d     = n_clamp;
          cnt_d   = '0;
          state_d = st_init;
        end
      end

      st_lw: begin
        wd_ready = 1'b1;
        a        = cnt_q;
        write    = wd_valid;
        if (wd_valid) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = st_lb;
          end else begin
            cnt_d = cnt_q + aw'(1);
          end
        end
      end

      st_lb: begin
        wd_ready = 1'b1;
        a        = bias_addr;
        if (wd_valid) begin
          write     = 1'b1;
          bwrite    = 1'b1;
          load_done = 1'b1;
          state_d   = st_idle;
        end
      end

      st_init: begin
        init    = 1'b1;
        cnt_d   = '0;
        state_d = (n_q != '0) ? st_run : st_bias;
      end

      st_run: begin
        exec = 1'b1;
        a    = cnt_q;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = st_bias;
        end else begin
          cnt_d = cnt_q + aw'(1);
        end
      end

      st_bias: begin
        bias    = 1'b1;
        a       = bias_addr;
        state_d = st_dr1;
      end

      // Two drain cycles cover the core's two-stage MAC pipeline.
      st_dr1: state_d = st_dr2;
      st_dr2: state_d = st_res;

      st_res: begin
        res_valid = 1'b1;
        if (res_ready) state_d = st_idle;
      end

      default: state_d = st_idle;
    endcase
  end

endmodule
